comparator_8bit_d: RTL and testbench



---
 rtl/cmp_pkg.sv | 12 +
 rtl/comparator_4bit_slice.sv | 32 +++
 rtl/comparator_8bit_d.sv | 62 ++++++
 tb/tb_comparator_8bit_d.sv | 121 ++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the cascaded magnitude comparator.
package cmp_pkg;

  localparam int SLICE_W = 4;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_flags_t;

endpackage

// File: rtl/comparator_4bit_slice.sv
// Combinational 4-bit unsigned compare slice, resolved MSB-first without subtraction.
module comparator_4bit_slice
  import cmp_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic               gt,
  output logic               lt,
  output logic               eq
);

  logic [SLICE_W-1:0] gt_bit;
  logic [SLICE_W-1:0] lt_bit;
  logic [SLICE_W-1:0] eq_bit;

  assign gt_bit = a & ~b;
  assign lt_bit = ~a & b;
  assign eq_bit = ~(a ^ b);

  // A lower bit only matters while every more significant bit has matched.
  always_comb begin
    gt = 1'b0;
    lt = 1'b0;
    eq = 1'b1;
    for (int i = SLICE_W - 1; i >= 0; i--) begin
      gt = gt | (eq & gt_bit[i]);
      lt = lt | (eq & lt_bit[i]);
      eq = eq & eq_bit[i];
    end
  end

endmodule

// File: rtl/comparator_8bit_d.sv
// Registered unsigned magnitude comparator: cascaded 4-bit slices feeding one output register.
module comparator_8bit_d
  import cmp_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SLICE_W = cmp_pkg::SLICE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             greater,
  output logic             less,
  output logic             equal
);

  localparam int NSLICE = WIDTH / SLICE_W;

  cmp_flags_t slice_p0 [NSLICE];
  cmp_flags_t flags_p0;
  cmp_flags_t flags_p1;
  logic       vld_p1;

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    comparator_4bit_slice u_slice (
      .a  (a[i*SLICE_W +: SLICE_W]),
      .b  (b[i*SLICE_W +: SLICE_W]),
      .gt (slice_p0[i].gt),
      .lt (slice_p0[i].lt),
      .eq (slice_p0[i].eq)
    );
  end

  always_comb begin
    flags_p0.gt = 1'b0;
    flags_p0.lt = 1'b0;
    flags_p0.eq = 1'b1;
    for (int i = NSLICE - 1; i >= 0; i--) begin
      flags_p0.gt = flags_p0.gt | (flags_p0.eq & slice_p0[i].gt);
      flags_p0.lt = flags_p0.lt | (flags_p0.eq & slice_p0[i].lt);
      flags_p0.eq = flags_p0.eq & slice_p0[i].eq;
    end
  end

  // p0 -> p1: output register; reset forces the all-zero "no result" state.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      flags_p1 <= flags_p0;
      vld_p1   <= 1'b1;
    end
  end

  assign greater = flags_p1.gt;
  assign less    = flags_p1.lt;
  assign equal   = flags_p1.eq;

  a_onehot : assert property (@(posedge clk) vld_p1 |-> $onehot({greater, less, equal}));

endmodule

// File: tb/tb_comparator_8bit_d.sv
// Directed and exhaustive checks for comparator_8bit_d; flags compared as {greater, less, equal}.
module tb_comparator_8bit_d;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  logic       greater;
  logic       less;
  logic       equal;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [2:0] GT   = 3'b100;
  localparam logic [2:0] LT   = 3'b010;
  localparam logic [2:0] EQ   = 3'b001;
  localparam logic [2:0] NONE = 3'b000;

  comparator_8bit_d #(.WIDTH(8), .SLICE_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .greater (greater),
    .less    (less),
    .equal   (equal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got gle=%b, expected gle=%b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] model(input logic [7:0] x, input logic [7:0] y);
    if (x > y)      return GT;
    else if (x < y) return LT;
    else            return EQ;
  endfunction

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [2:0] exp;
    string      tag;
  } vec_t;

  vec_t vecs[$];
  int   sweep_err;

  initial begin
    vecs = '{
      '{8'h00, 8'h00, EQ, "zero_eq"},
      '{8'hFF, 8'hFF, EQ, "ff_eq"},
      '{8'h80, 8'h01, GT, "hi_slice_gt"},
      '{8'h0F, 8'h70, LT, "hi_slice_lt"},
      '{8'hFC, 8'hA0, GT, "fc_a0_gt"},
      '{8'h5A, 8'h5B, LT, "lo_slice_lt"},
      '{8'h10, 8'h10, EQ, "b2b_eq"},
      '{8'h11, 8'h10, GT, "b2b_gt"},
      '{8'h0F, 8'h10, LT, "b2b_lt"},
      '{8'h01, 8'h00, GT, "bit0_gt"},
      '{8'hFE, 8'hFF, LT, "bit0_lt"},
      '{8'h80, 8'h00, GT, "bit7_gt"},
      '{8'h7F, 8'hFF, LT, "bit7_lt"}
    };

    reset = 1'b1;
    a = 8'h3C;
    b = 8'h11;
    tick();
    chk("reset_c1", {greater, less, equal}, NONE);
    tick();
    chk("reset_c2", {greater, less, equal}, NONE);
    reset = 1'b0;
    tick();
    chk("reset_release", {greater, less, equal}, GT);

    // Operands change every cycle; each result is visible right after the capturing edge.
    foreach (vecs[i]) begin
      a = vecs[i].va;
      b = vecs[i].vb;
      tick();
      chk(vecs[i].tag, {greater, less, equal}, vecs[i].exp);
    end

    sweep_err = 0;
    for (int i = 0; i < 65536; i++) begin
      a = i[15:8];
      b = i[7:0];
      reset = (i == 30000);
      tick();
      if (i == 30000) begin
        chk("mid_sweep_reset", {greater, less, equal}, NONE);
      end else begin
        if ({greater, less, equal} !== model(a, b) && sweep_err < 10) begin
          sweep_err++;
          chk($sformatf("sweep_%02h_%02h", a, b), {greater, less, equal}, model(a, b));
        end else if ({greater, less, equal} !== model(a, b)) begin
          n_checks++;
        end else begin
          n_checks++;
          n_pass++;
        end
      end
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
